// File: rtl/sram_arb2_if.sv
// sram_arb2_if: one requester port of the SRAM arbiter (master = requester side, slave = arbiter side)
interface sram_arb2_if #(
  parameter int AW = 14,
  parameter int DW = 32
);
  logic            req;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   wdata;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;
  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_arb2.sv
// sram_arb2: two-port arbiter/sequencer for a single-port sync SRAM (P0 fetch, P1 load/store), SRAM_ARB_RR_EN selects round-robin
module sram_arb2 #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rstn,
  sram_arb2_if.slave      p0,
  sram_arb2_if.slave      p1,
  output logic            sram_cs,
  output logic            sram_we,
  output logic [AW-1:0]   sram_a,
  output logic [DW/8-1:0] sram_byte,
  output logic [DW-1:0]   sram_di,
  input  logic [DW-1:0]   sram_do
);
  logic en, rsp_v, rsp_id, rsp_rd, pick1, g0, g1;
`ifdef SRAM_ARB_RR_EN
  logic last_gnt;
  assign pick1 = ~last_gnt;
`else
  assign pick1 = 1'b0;
`endif
  always_comb begin
    g0        = en & p0.req & ~(p1.req & pick1);
    g1        = en & p1.req & ~g0;
    sram_cs   = g0 | g1;
    sram_we   = g0 ? p0.we    : g1 ? p1.we    : 1'b0;
    sram_a    = g0 ? p0.addr  : g1 ? p1.addr  : '0;
    sram_byte = g0 ? p0.be    : g1 ? p1.be    : '0;
    sram_di   = g0 ? p0.wdata : g1 ? p1.wdata : '0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en     <= 1'b0;
      rsp_v  <= 1'b0;
      rsp_id <= 1'b0;
      rsp_rd <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      en    <= 1'b1;
      rsp_v <= sram_cs;
      if (sram_cs) begin
        rsp_id <= g1;
        rsp_rd <= ~sram_we;
`ifdef SRAM_ARB_RR_EN
        last_gnt <= g1;
`endif
      end
    end
  end
  assign p0.gnt    = g0;
  assign p1.gnt    = g1;
  assign p0.rvalid = rsp_v & ~rsp_id;
  assign p1.rvalid = rsp_v & rsp_id;
  assign p0.rdata  = (rsp_v & rsp_rd & ~rsp_id) ? sram_do : '0;
  assign p1.rdata  = (rsp_v & rsp_rd & rsp_id) ? sram_do : '0;
endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2: randomized and directed checks of sram_arb2 against a behavioural SRAM and reference model
module tb_sram_arb2;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sram_cs, sram_we;
  logic [13:0] sram_a;
  logic [3:0] sram_byte;
  logic [31:0] sram_di;
  logic [31:0] sram_do;
  logic [31:0] mem [16384];
  logic [31:0] ref_mem [16];
  sram_arb2_if #(.AW(14), .DW(32)) p0_if ();
  sram_arb2_if #(.AW(14), .DW(32)) p1_if ();
  sram_arb2 #(.AW(14), .DW(32)) dut (
    .clk(clk), .rstn(rstn), .p0(p0_if), .p1(p1_if),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a),
    .sram_byte(sram_byte), .sram_di(sram_di), .sram_do(sram_do)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_byte[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
      end else begin
        sram_do <= mem[sram_a];
      end
    end
  end

  task automatic idle();
    p0_if.req = 0; p0_if.we = 0; p0_if.addr = 0; p0_if.be = 0; p0_if.wdata = 0;
    p1_if.req = 0; p1_if.we = 0; p1_if.addr = 0; p1_if.be = 0; p1_if.wdata = 0;
  endtask

  task automatic set_p(input int n, input logic we, input logic [13:0] a, input logic [3:0] b, input logic [31:0] d);
    if (n == 0) begin
      p0_if.req = 1; p0_if.we = we; p0_if.addr = a; p0_if.be = b; p0_if.wdata = d;
    end else begin
      p1_if.req = 1; p1_if.we = we; p1_if.addr = a; p1_if.be = b; p1_if.wdata = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    idle();
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 0;
    set_p(0, 0, 14'h5, 4'h0, 0);
    #1;
    total++;
    if (p0_if.gnt !== 1'b0 || sram_cs !== 1'b0 || p0_if.rvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: gnt=%b cs=%b rvalid=%b required 0 0 0", p0_if.gnt, sram_cs, p0_if.rvalid);
    end
    @(negedge clk);
    rstn = 1;
    #1;
    total++;
    if (p0_if.gnt !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_cycle: gnt0=%b required 0", p0_if.gnt);
    end
    @(negedge clk);
    total++;
    if (p0_if.gnt !== 1'b1 || sram_cs !== 1'b1) begin
      bad++;
      $display("FAIL reset_enable: gnt0=%b cs=%b required 1 1", p0_if.gnt, sram_cs);
    end
    idle();
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    set_p(1, 1, 14'h10, 4'hF, 32'h11223344);
    #1;
    total++;
    if (p1_if.gnt !== 1'b1 || sram_we !== 1'b1 || sram_a !== 14'h10) begin
      bad++;
      $display("FAIL bw_gnt1: gnt1=%b we=%b a=%h required 1 1 0010", p1_if.gnt, sram_we, sram_a);
    end
    @(negedge clk);
    set_p(1, 1, 14'h10, 4'b0101, 32'hAABBCCDD);
    total++;
    if (p1_if.rvalid !== 1'b1 || p1_if.rdata !== 32'h0 || p0_if.rvalid !== 1'b0) begin
      bad++;
      $display("FAIL bw_wr_done: rvalid1=%b rdata1=%h rvalid0=%b required 1 00000000 0", p1_if.rvalid, p1_if.rdata, p0_if.rvalid);
    end
    @(negedge clk);
    set_p(1, 0, 14'h10, 4'h0, 32'h0);
    #1;
    total++;
    if (p1_if.gnt !== 1'b1 || sram_we !== 1'b0) begin
      bad++;
      $display("FAIL bw_rd_gnt: gnt1=%b we=%b required 1 0", p1_if.gnt, sram_we);
    end
    @(negedge clk);
    idle();
    total++;
    if (p1_if.rvalid !== 1'b1 || p1_if.rdata !== 32'h11BB33DD || p0_if.rvalid !== 1'b0) begin
      bad++;
      $display("FAIL bw_rdata: rvalid1=%b rdata1=%h rvalid0=%b required 1 11bb33dd 0", p1_if.rvalid, p1_if.rdata, p0_if.rvalid);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] dv [2];
    int w, prev;
    dv[0] = 32'h0100_5A5A;
    dv[1] = 32'h0200_A5A5;
    do_reset();
    mem[14'h100] = dv[0];
    mem[14'h200] = dv[1];
    set_p(0, 0, 14'h100, 4'h0, 0);
    set_p(1, 0, 14'h200, 4'h0, 0);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      w = RR ? (i % 2) : 0;
      total++;
      if (p0_if.gnt !== (w == 0) || p1_if.gnt !== (w == 1)) begin
        bad++;
        $display("FAIL conflict_gnt[%0d]: gnt0=%b gnt1=%b required winner P%0d", i, p0_if.gnt, p1_if.gnt, w);
      end
      if (i > 0) begin
        total++;
        if ((prev == 0 ? p0_if.rvalid : p1_if.rvalid) !== 1'b1 || (prev == 0 ? p1_if.rvalid : p0_if.rvalid) !== 1'b0
            || (prev == 0 ? p0_if.rdata : p1_if.rdata) !== dv[prev] || (prev == 0 ? p1_if.rdata : p0_if.rdata) !== 32'h0) begin
          bad++;
          $display("FAIL conflict_rsp[%0d]: rv0=%b rv1=%b rd0=%h rd1=%h required owner P%0d data %h", i,
                   p0_if.rvalid, p1_if.rvalid, p0_if.rdata, p1_if.rdata, prev, dv[prev]);
        end
      end
      prev = w;
      @(negedge clk);
    end
    p0_if.req = 0;
    #1;
    total++;
    if (p1_if.gnt !== 1'b1 || p0_if.gnt !== 1'b0) begin
      bad++;
      $display("FAIL conflict_release: gnt0=%b gnt1=%b required 0 1", p0_if.gnt, p1_if.gnt);
    end
    @(negedge clk);
    idle();
    total++;
    if (p1_if.rvalid !== 1'b1 || p1_if.rdata !== dv[1] || p0_if.rdata !== 32'h0) begin
      bad++;
      $display("FAIL conflict_p1_data: rv1=%b rd1=%h rd0=%h required 1 %h 0", p1_if.rvalid, p1_if.rdata, p0_if.rdata, dv[1]);
    end
  endtask

  task automatic test_top_addr();
    @(negedge clk);
    set_p(0, 1, 14'h3FFF, 4'hF, 32'hDEADBEEF);
    #1;
    total++;
    if (p0_if.gnt !== 1'b1 || sram_a !== 14'h3FFF || sram_di !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL top_wr: gnt0=%b a=%h di=%h required 1 3fff deadbeef", p0_if.gnt, sram_a, sram_di);
    end
    @(negedge clk);
    set_p(0, 0, 14'h3FFF, 4'h0, 0);
    #1;
    total++;
    if (p0_if.gnt !== 1'b1 || sram_we !== 1'b0 || sram_a !== 14'h3FFF) begin
      bad++;
      $display("FAIL top_rd_gnt: gnt0=%b we=%b a=%h required 1 0 3fff", p0_if.gnt, sram_we, sram_a);
    end
    @(negedge clk);
    idle();
    total++;
    if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL top_rdata: rvalid0=%b rdata0=%h required 1 deadbeef", p0_if.rvalid, p0_if.rdata);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_p(0, 0, 14'h3FFF, 4'h0, 0);
    @(posedge clk);
    #1;
    total++;
    if (p0_if.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pending: rvalid0=%b required 1", p0_if.rvalid);
    end
    rstn = 0;
    #1;
    total++;
    if (p0_if.rvalid !== 1'b0 || p0_if.gnt !== 1'b0 || sram_cs !== 1'b0) begin
      bad++;
      $display("FAIL mid_drop: rvalid0=%b gnt0=%b cs=%b required 0 0 0", p0_if.rvalid, p0_if.gnt, sram_cs);
    end
    idle();
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (p0_if.rvalid !== 1'b0 || p1_if.rvalid !== 1'b0) begin
        bad++;
        $display("FAIL mid_stale[%0d]: rvalid0=%b rvalid1=%b required 0 0", i, p0_if.rvalid, p1_if.rvalid);
      end
    end
  endtask

  task automatic test_random();
    bit pend [2];
    bit pwe [2];
    logic [3:0] pa [2];
    logic [3:0] pb [2];
    logic [31:0] pd [2];
    bit exp_v [2];
    bit exp_rd;
    logic [31:0] exp_d;
    int prefer, w;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      mem[i] = ref_mem[i];
    end
    pend = '{0, 0};
    exp_v = '{0, 0};
    exp_rd = 0;
    exp_d = 0;
    prefer = 0;
    for (int c = 0; c < 300; c++) begin
      total++;
      if (p0_if.rvalid !== exp_v[0] || p1_if.rvalid !== exp_v[1]
          || p0_if.rdata !== ((exp_v[0] && exp_rd) ? exp_d : 32'h0)
          || p1_if.rdata !== ((exp_v[1] && exp_rd) ? exp_d : 32'h0)) begin
        bad++;
        $display("FAIL rand_rsp[%0d]: rv0=%b rv1=%b rd0=%h rd1=%h required rv=%b%b rd=%b data=%h", c,
                 p0_if.rvalid, p1_if.rvalid, p0_if.rdata, p1_if.rdata, exp_v[0], exp_v[1], exp_rd, exp_d);
      end
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) != 0) begin
          pend[n] = 1;
          pwe[n] = 1'($urandom_range(0, 1));
          pa[n] = 4'($urandom_range(0, 15));
          pb[n] = 4'($urandom);
          pd[n] = $urandom;
          set_p(n, pwe[n], {10'h0, pa[n]}, pb[n], pd[n]);
        end else if (!pend[n]) begin
          if (n == 0) p0_if.req = 0; else p1_if.req = 0;
        end
      end
      #1;
      w = (pend[0] && pend[1]) ? (RR ? prefer : 0) : pend[0] ? 0 : pend[1] ? 1 : -1;
      total++;
      if (p0_if.gnt !== (w == 0) || p1_if.gnt !== (w == 1)) begin
        bad++;
        $display("FAIL rand_gnt[%0d]: gnt0=%b gnt1=%b required winner %0d", c, p0_if.gnt, p1_if.gnt, w);
      end
      exp_v = '{0, 0};
      if (w >= 0) begin
        exp_v[w] = 1;
        exp_rd = !pwe[w];
        if (pwe[w]) begin
          for (int b = 0; b < 4; b++)
            if (pb[w][b]) ref_mem[pa[w]][8*b +: 8] = pd[w][8*b +: 8];
        end else begin
          exp_d = ref_mem[pa[w]];
        end
        pend[w] = 0;
        prefer = 1 - w;
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_byte_write();
    test_top_addr();
    test_conflict();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
